// File: rtl/debug_cmd_pkg.sv
// debug_cmd_pkg: opcodes, engine states, error response byte and transfer count width
package debug_cmd_pkg;
  localparam int CNT_W = 16;
  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_ECHO   = 4'h1;
  localparam logic [3:0] OP_MEM_RD = 4'h2;
  localparam logic [3:0] OP_MEM_WR = 4'h3;
  localparam logic [3:0] OP_VAL_RD = 4'h4;
  localparam logic [3:0] OP_VAL_WR = 4'h5;
  localparam logic [7:0] TX_ACK_ERR = 8'hEE;
  typedef enum logic [3:0] {
    IDLE, HDR, MEM_RD_ISSUE, MEM_RD_WAIT, MEM_RD_HOLD, MEM_WR_DATA,
    VAL_RD_WAIT, VAL_RD_SHIFT, VAL_WR_DATA, VAL_WR_COMMIT, ECHO
  } state_t;
  function automatic logic is_mem_op(input logic [3:0] op);
    return op == OP_MEM_RD || op == OP_MEM_WR;
  endfunction
endpackage

// File: rtl/debug_hdr_shifter.sv
// debug_hdr_shifter: MSB-first byte collector with byte counter and done flag
module debug_hdr_shifter #(
  parameter int NBYTES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                shift,
  input  logic [7:0]          din,
  output logic [NBYTES*8-1:0] nxt,
  output logic                last
);
  localparam int CW = $clog2(NBYTES + 1);
  logic [NBYTES*8-1:0] data;
  logic [CW-1:0] cnt;
  logic done;
  // nxt is the collected value including the byte being shifted this cycle
  assign nxt = (data << 8) | (NBYTES*8)'(din);
  assign last = shift && !done && cnt == CW'(NBYTES - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      data <= '0;
      cnt <= '0;
      done <= 1'b0;
    end else if (clear) begin
      data <= '0;
      cnt <= '0;
      done <= 1'b0;
    end else if (shift && !done) begin
      data <= nxt;
      cnt <= cnt + CW'(1);
      done <= last;
    end
endmodule

// File: rtl/debug_cmd_engine.sv
// debug_cmd_engine: SPI byte-stream command processor for memory bursts and value registers
// Define DEBUG_CMD_ENGINE_STATUS_EN to add state/count/sticky-error status ports.
module debug_cmd_engine
  import debug_cmd_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int NUM_MEM    = 2,
  parameter int VALUE_W    = 16,
  parameter int VALUE_ID_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_sync_clear,
  input  logic                  i_rx_dv,
  input  logic [7:0]            i_rx_byte,
  output logic                  o_tx_dv,
  output logic [7:0]            o_tx_byte,
  output logic [ADDR_W-1:0]     o_mem_addr,
  output logic [NUM_MEM-1:0]    o_mem_en,
  output logic                  o_mem_rw,
  output logic [7:0]            o_mem_data,
  input  logic [8*NUM_MEM-1:0]  i_mem_data,
  output logic [VALUE_ID_W-1:0] o_value_id,
  output logic                  o_value_en,
  output logic                  o_value_rw,
  output logic [VALUE_W-1:0]    o_value_data,
  input  logic [VALUE_W-1:0]    i_value_data
`ifdef DEBUG_CMD_ENGINE_STATUS_EN
  ,
  output logic [3:0]            o_debug_state,
  output logic [15:0]           o_debug_bytes_remaining,
  output logic                  o_debug_error
`endif
);
  localparam int AB = (ADDR_W + 7) / 8;
  localparam int VB = (VALUE_W + 7) / 8;
  localparam int IB = (VALUE_ID_W + 7) / 8;
  localparam int HB = AB + 2;
  state_t st, nst;
  logic rx, cmd_ok, sh_clr, h_last, id_last, w_last;
  logic [3:0] op, opc, tgt;
  logic [HB*8-1:0] hn;
  logic [IB*8-1:0] idn;
  logic [VB*8-1:0] wn, vpad, vsh;
  logic [CNT_W-1:0] cnt;
  logic [NUM_MEM-1:0] sel;
  logic [7:0] rd_byte;
  assign rx = i_rx_dv && !i_sync_clear;
  assign op = i_rx_byte[7:4];
  assign cmd_ok = op <= OP_VAL_WR && !(is_mem_op(op) && int'(i_rx_byte[3:0]) >= NUM_MEM);
  assign sh_clr = st == IDLE || i_sync_clear;
  assign sel = NUM_MEM'(1) << tgt;
  assign rd_byte = 8'(i_mem_data >> {tgt, 3'b000});
  assign vpad = (VB*8)'(i_value_data);
  debug_hdr_shifter #(.NBYTES(HB)) u_hdr (
    .clk(i_clk), .rst(i_reset), .clear(sh_clr),
    .shift(st == HDR && rx && is_mem_op(opc)), .din(i_rx_byte), .nxt(hn), .last(h_last)
  );
  debug_hdr_shifter #(.NBYTES(IB)) u_id (
    .clk(i_clk), .rst(i_reset), .clear(sh_clr),
    .shift(st == HDR && rx && !is_mem_op(opc)), .din(i_rx_byte), .nxt(idn), .last(id_last)
  );
  debug_hdr_shifter #(.NBYTES(VB)) u_wdat (
    .clk(i_clk), .rst(i_reset), .clear(sh_clr),
    .shift(st == VAL_WR_DATA && rx), .din(i_rx_byte), .nxt(wn), .last(w_last)
  );
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) st <= IDLE;
    else st <= nst;
  always_comb begin
    nst = st;
    if (i_sync_clear) nst = IDLE;
    else
      case (st)
        IDLE:          if (rx && cmd_ok && op != OP_NOP) nst = op == OP_ECHO ? ECHO : HDR;
        ECHO:          if (rx) nst = IDLE;
        HDR:
          if (h_last) nst = hn[CNT_W-1:0] == '0 ? IDLE : opc == OP_MEM_RD ? MEM_RD_ISSUE : MEM_WR_DATA;
          else if (id_last) nst = opc == OP_VAL_RD ? VAL_RD_WAIT : VAL_WR_DATA;
        MEM_RD_ISSUE:  nst = MEM_RD_WAIT;
        MEM_RD_WAIT:   nst = MEM_RD_HOLD;
        MEM_RD_HOLD:   if (rx) nst = cnt == CNT_W'(1) ? IDLE : MEM_RD_ISSUE;
        MEM_WR_DATA:   if (rx && cnt == CNT_W'(1)) nst = IDLE;
        VAL_RD_WAIT:   if (!o_value_en) nst = VAL_RD_SHIFT;
        VAL_RD_SHIFT:  if (rx && cnt == '0) nst = IDLE;
        VAL_WR_DATA:   if (w_last) nst = VAL_WR_COMMIT;
        VAL_WR_COMMIT: nst = IDLE;
        default:       nst = IDLE;
      endcase
  end
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      o_tx_dv <= 1'b0;
      o_tx_byte <= '0;
      o_mem_addr <= '0;
      o_mem_en <= '0;
      o_mem_rw <= 1'b1;
      o_mem_data <= '0;
      o_value_id <= '0;
      o_value_en <= 1'b0;
      o_value_rw <= 1'b1;
      o_value_data <= '0;
      opc <= '0;
      tgt <= '0;
      cnt <= '0;
      vsh <= '0;
    end else begin
      o_tx_dv <= 1'b0;
      o_mem_en <= '0;
      o_mem_rw <= 1'b1;
      o_value_en <= 1'b0;
      o_value_rw <= 1'b1;
      // a write pulse that is on the bus now lands, then the burst address moves on
      if (|o_mem_en && !o_mem_rw) o_mem_addr <= o_mem_addr + ADDR_W'(1);
      if (!i_sync_clear)
        case (st)
          IDLE:
            if (rx) begin
              o_tx_dv <= 1'b1;
              o_tx_byte <= cmd_ok ? i_rx_byte : TX_ACK_ERR;
              opc <= op;
              tgt <= i_rx_byte[3:0];
            end
          ECHO:
            if (rx) begin
              o_tx_dv <= 1'b1;
              o_tx_byte <= i_rx_byte;
            end
          HDR:
            if (h_last) begin
              o_mem_addr <= hn[CNT_W +: ADDR_W];
              cnt <= hn[CNT_W-1:0];
              if (opc == OP_MEM_RD && hn[CNT_W-1:0] != '0) o_mem_en <= sel;
            end else if (id_last) begin
              o_value_id <= idn[VALUE_ID_W-1:0];
              o_value_en <= opc == OP_VAL_RD;
            end
          MEM_RD_WAIT: begin
            o_tx_dv <= 1'b1;
            o_tx_byte <= rd_byte;
          end
          MEM_RD_HOLD:
            if (rx) begin
              o_mem_addr <= o_mem_addr + ADDR_W'(1);
              cnt <= cnt - CNT_W'(1);
              if (cnt != CNT_W'(1)) o_mem_en <= sel;
            end
          MEM_WR_DATA:
            if (rx) begin
              o_mem_en <= sel;
              o_mem_rw <= 1'b0;
              o_mem_data <= i_rx_byte;
              cnt <= cnt - CNT_W'(1);
            end
          VAL_RD_WAIT:
            if (!o_value_en) begin
              o_tx_dv <= 1'b1;
              o_tx_byte <= vpad[VB*8-1 -: 8];
              vsh <= vpad << 8;
              cnt <= CNT_W'(VB - 1);
            end
          VAL_RD_SHIFT:
            if (rx && cnt != '0) begin
              o_tx_dv <= 1'b1;
              o_tx_byte <= vsh[VB*8-1 -: 8];
              vsh <= vsh << 8;
              cnt <= cnt - CNT_W'(1);
            end
          VAL_WR_DATA:
            if (w_last) begin
              o_value_en <= 1'b1;
              o_value_rw <= 1'b0;
              o_value_data <= wn[VALUE_W-1:0];
            end
          default: ;
        endcase
    end
`ifdef DEBUG_CMD_ENGINE_STATUS_EN
  assign o_debug_state = st;
  assign o_debug_bytes_remaining = cnt;
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) o_debug_error <= 1'b0;
    else if (i_sync_clear) o_debug_error <= 1'b0;
    else if (st == IDLE && rx && !cmd_ok) o_debug_error <= 1'b1;
`endif
endmodule

// File: tb/tb_debug_cmd_engine.sv
// tb_debug_cmd_engine: randomized transactions checked against a transaction-level model
module tb_debug_cmd_engine;
  localparam int NM = 2;
  logic clk = 0, rst = 1, sync_clear = 0, rx_dv = 0;
  logic [7:0] rx_byte = 0;
  logic tx_dv, mem_rw, value_en, value_rw;
  logic [7:0] tx_byte, mem_data;
  logic [15:0] mem_addr, value_id, value_data, value_rdata;
  logic [NM-1:0] mem_en;
  logic [8*NM-1:0] mem_rdata;
`ifdef DEBUG_CMD_ENGINE_STATUS_EN
  logic [3:0] dbg_state;
  logic [15:0] dbg_rem;
  logic dbg_err;
`endif
  debug_cmd_engine #(.ADDR_W(16), .NUM_MEM(NM), .VALUE_W(16), .VALUE_ID_W(16)) dut (
    .i_clk(clk), .i_reset(rst), .i_sync_clear(sync_clear), .i_rx_dv(rx_dv), .i_rx_byte(rx_byte),
    .o_tx_dv(tx_dv), .o_tx_byte(tx_byte), .o_mem_addr(mem_addr), .o_mem_en(mem_en),
    .o_mem_rw(mem_rw), .o_mem_data(mem_data), .i_mem_data(mem_rdata),
    .o_value_id(value_id), .o_value_en(value_en), .o_value_rw(value_rw),
    .o_value_data(value_data), .i_value_data(value_rdata)
`ifdef DEBUG_CMD_ENGINE_STATUS_EN
    , .o_debug_state(dbg_state), .o_debug_bytes_remaining(dbg_rem), .o_debug_error(dbg_err)
`endif
  );
  always #5 clk = ~clk;
  // memory and value blocks seen by the engine
  bit [7:0] env_mem [NM][65536];
  bit [15:0] env_val [65536];
  logic [7:0] mem_q [NM];
  always @(posedge clk) begin
    for (int k = 0; k < NM; k++)
      if (mem_en[k]) begin
        if (!mem_rw) env_mem[k][mem_addr] <= mem_data;
        mem_q[k] <= env_mem[k][mem_addr];
      end
    if (value_en) begin
      if (!value_rw) env_val[value_id] <= value_data;
      value_rdata <= env_val[value_id];
    end
  end
  always_comb
    for (int k = 0; k < NM; k++) mem_rdata[8*k +: 8] = mem_q[k];
  // reference contents
  bit [7:0] gmem [NM][65536];
  bit [15:0] gval [65536];
  int cyc = 0, last_rx = 0, cmd_cyc = 0, n_tests = 0, n_fail = 0;
  logic [7:0] txq[$], exp_tx[$];
  int txc[$];
  logic [63:0] memq[$], exp_mem[$], valq[$], exp_val[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (!rst) begin
      if (tx_dv) begin
        txq.push_back(tx_byte);
        txc.push_back(cyc);
      end
      if (|mem_en) memq.push_back(64'({mem_en, mem_rw, mem_addr, mem_rw ? 8'h00 : mem_data}));
      if (value_en) valq.push_back(64'({value_rw, value_id, value_rw ? 16'h0 : value_data}));
    end
  function automatic logic [63:0] mrec(input int t, input logic rw, input logic [15:0] a, input logic [7:0] d);
    logic [NM-1:0] en;
    en = NM'(1) << t;
    return 64'({en, rw, a, rw ? 8'h00 : d});
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_dv = 1;
    rx_byte = b;
    last_rx = cyc;
    @(posedge clk);
    #1;
    rx_dv = 0;
    repeat (4) @(posedge clk);
  endtask
  task automatic send_cmd(input logic [7:0] c);
    send(c);
    cmd_cyc = last_rx;
  endtask
  task automatic flush(input string tag);
    repeat (8) @(posedge clk);
    check({tag, "/tx_n"}, txq.size(), exp_tx.size());
    foreach (exp_tx[i]) check({tag, "/tx"}, i < txq.size() ? 64'(txq[i]) : 'x, exp_tx[i]);
    if (txq.size() > 0 && exp_tx.size() > 0) check({tag, "/ack_lat"}, txc[0] - cmd_cyc, 1);
    check({tag, "/mem_n"}, memq.size(), exp_mem.size());
    foreach (exp_mem[i]) check({tag, "/mem"}, i < memq.size() ? memq[i] : 'x, exp_mem[i]);
    check({tag, "/val_n"}, valq.size(), exp_val.size());
    foreach (exp_val[i]) check({tag, "/val"}, i < valq.size() ? valq[i] : 'x, exp_val[i]);
    txq.delete(); txc.delete(); memq.delete(); valq.delete();
    exp_tx.delete(); exp_mem.delete(); exp_val.delete();
  endtask
  task automatic t_echo(input logic [7:0] b);
    logic [7:0] c;
    c = {4'h1, 4'($urandom_range(0, 15))};
    send_cmd(c);
    send(b);
    exp_tx.push_back(c);
    exp_tx.push_back(b);
    flush("echo");
  endtask
  task automatic t_mem_wr(input int t, input logic [15:0] a, input int n, input logic [31:0] d);
    logic [7:0] c, b;
    logic [15:0] aa;
    c = {4'h3, 4'(t)};
    send_cmd(c);
    send(a[15:8]); send(a[7:0]); send(8'(n >> 8)); send(8'(n));
    exp_tx.push_back(c);
    for (int i = 0; i < n; i++) begin
      b = 8'(d >> (8 * i));
      aa = a + 16'(i);
      send(b);
      exp_mem.push_back(mrec(t, 1'b0, aa, b));
      gmem[t][aa] = b;
    end
    flush("mem_wr");
  endtask
  task automatic t_mem_rd(input int t, input logic [15:0] a, input int n);
    logic [7:0] c;
    logic [15:0] aa;
    int h;
    c = {4'h2, 4'(t)};
    send_cmd(c);
    send(a[15:8]); send(a[7:0]); send(8'(n >> 8)); send(8'(n));
    h = last_rx;
    exp_tx.push_back(c);
    for (int i = 0; i < n; i++) begin
      aa = a + 16'(i);
      exp_tx.push_back(gmem[t][aa]);
      exp_mem.push_back(mrec(t, 1'b1, aa, 8'h00));
    end
    for (int i = 0; i < n; i++) send(8'($urandom));
    if (n > 0) check("rd_lat", txc.size() > 1 ? txc[1] - h : -1, 3);
    flush("mem_rd");
  endtask
  task automatic t_val_wr(input logic [15:0] id, input logic [15:0] v);
    logic [7:0] c;
    c = {4'h5, 4'($urandom_range(0, 15))};
    send_cmd(c);
    send(id[15:8]); send(id[7:0]); send(v[15:8]); send(v[7:0]);
    exp_tx.push_back(c);
    exp_val.push_back(64'({1'b0, id, v}));
    gval[id] = v;
    flush("val_wr");
  endtask
  task automatic t_val_rd(input logic [15:0] id);
    logic [7:0] c;
    c = {4'h4, 4'($urandom_range(0, 15))};
    send_cmd(c);
    send(id[15:8]); send(id[7:0]);
    send(8'($urandom)); send(8'($urandom));
    exp_tx.push_back(c);
    exp_tx.push_back(gval[id][15:8]);
    exp_tx.push_back(gval[id][7:0]);
    exp_val.push_back(64'({1'b1, id, 16'h0}));
    flush("val_rd");
  endtask
  task automatic t_err(input logic [7:0] c);
    send_cmd(c);
    exp_tx.push_back(8'hEE);
`ifdef DEBUG_CMD_ENGINE_STATUS_EN
    check("dbg_err_set", dbg_err, 1);
`endif
    flush("err");
  endtask
  task automatic t_nop();
    logic [7:0] c;
    c = {4'h0, 4'($urandom_range(0, 15))};
    send_cmd(c);
    exp_tx.push_back(c);
    flush("nop");
  endtask
  task automatic check_rst_vals(input string tag);
    check({tag, "/mem_rw"}, mem_rw, 1);
    check({tag, "/value_rw"}, value_rw, 1);
    check({tag, "/mem_en"}, mem_en, 0);
    check({tag, "/value_en"}, value_en, 0);
    check({tag, "/tx_dv"}, tx_dv, 0);
    check({tag, "/tx_byte"}, tx_byte, 0);
    check({tag, "/mem_addr"}, mem_addr, 0);
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end
  initial begin
    logic [15:0] ids [4];
    ids = '{16'h0007, 16'h0008, 16'h1234, 16'hFFFF};
    repeat (3) @(posedge clk);
    #1;
    check_rst_vals("reset");
    rst = 0;
    repeat (3) @(posedge clk);
    t_echo(8'h5A);
    t_mem_wr(1, 16'h1234, 3, 32'h00CCBBAA);
    t_mem_rd(1, 16'h1234, 3);
    t_mem_rd(0, 16'hFFFF, 2);
    t_mem_rd(0, 16'h0100, 0);
    @(posedge clk);
    #3;
    rst = 1;
    #1;
    check_rst_vals("mid_reset");
    @(posedge clk);
    #1;
    rst = 0;
    t_echo(8'hC3);
    t_val_wr(16'h0007, 16'hBEEF);
    t_val_rd(16'h0007);
    t_err(8'h22);
    t_err(8'h90);
    send_cmd(8'h31);
    send(8'h12);
    send(8'h34);
    @(posedge clk);
    #1;
    sync_clear = 1;
    @(posedge clk);
    #1;
    sync_clear = 0;
    exp_tx.push_back(8'h31);
`ifdef DEBUG_CMD_ENGINE_STATUS_EN
    check("dbg_err_clr", dbg_err, 0);
`endif
    flush("abort");
    t_echo(8'h77);
    @(posedge clk);
    #1;
    rx_dv = 1;
    rx_byte = 8'h10;
    sync_clear = 1;
    @(posedge clk);
    #1;
    rx_dv = 0;
    sync_clear = 0;
    flush("clr_drop");
    t_echo(8'h1F);
    for (int n = 0; n < 60; n++) begin
      int t;
      logic [15:0] a;
      t = $urandom_range(0, NM - 1);
      a = $urandom_range(0, 3) == 0 ? 16'hFFFE : 16'h1230 + 16'($urandom_range(0, 15));
      case ($urandom_range(0, 7))
        0: t_echo(8'($urandom));
        1, 2: t_mem_wr(t, a, $urandom_range(0, 4), $urandom);
        3: t_mem_rd(t, a, $urandom_range(0, 4));
        4: t_val_wr(ids[$urandom_range(0, 3)], 16'($urandom));
        5: t_val_rd(ids[$urandom_range(0, 3)]);
        6: t_err($urandom_range(0, 1) == 0 ? {4'($urandom_range(6, 15)), 4'($urandom_range(0, 15))}
                                           : {4'($urandom_range(2, 3)), 4'($urandom_range(NM, 15))});
        default: t_nop();
      endcase
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/debug_cmd_engine.md
Name: debug_cmd_engine

Overview:
Parametrised successor to the single-memory/single-value debugger command processor. Parses the byte stream from the SPI peripheral (rx_dv/rx_byte), executes memory burst reads/writes against up to NUM_MEM memory targets and single reads/writes against a value register bank, and returns response bytes on tx_dv/tx_byte. It sits between the SPI peripheral and the memory/value blocks inside the debugger top.

Parameters:
ADDR_W, 16, memory address width; header carries ADDR_BYTES = ceil(ADDR_W/8) address bytes, MSB first
NUM_MEM, 2, number of memory targets (1..16); selected by the command byte's low nibble
VALUE_W, 16, value data width; VALUE_BYTES = ceil(VALUE_W/8), MSB first
VALUE_ID_W, 16, value id width; ID_BYTES = ceil(VALUE_ID_W/8), MSB first

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous active-high reset
i_sync_clear  in  1  synchronous abort (SPI chip-select deasserted); forces IDLE
i_rx_dv  in  1  one-cycle pulse: i_rx_byte valid
i_rx_byte  in  8  received byte
o_tx_dv  out  1  one-cycle pulse: o_tx_byte valid for the SPI peripheral to load
o_tx_byte  out  8  response byte
o_mem_addr  out  ADDR_W  shared memory address
o_mem_en  out  NUM_MEM  one-hot memory enable
o_mem_rw  out  1  1 = read, 0 = write
o_mem_data  out  8  memory write data
i_mem_data  in  8*NUM_MEM  read data, target k in bits [8k+7:8k]; valid 1 cycle after enable
o_value_id  out  VALUE_ID_W  value id
o_value_en  out  1  value enable
o_value_rw  out  1  1 = read, 0 = write
o_value_data  out  VALUE_W  value write data
i_value_data  in  VALUE_W  value read data; 1-cycle latency

Behaviour:
- Reset values: all outputs 0, except o_mem_rw = 1 and o_value_rw = 1. State = IDLE; counters = 0.
- Command byte: [7:4] opcode, [3:0] target. Opcodes: 0 NOP, 1 ECHO, 2 MEM_RD, 3 MEM_WR, 4 VAL_RD, 5 VAL_WR.
- Acceptance: when a command byte is accepted in IDLE, o_tx_byte = command byte and o_tx_dv pulses on the next cycle.
- Error path: an unknown opcode, or a MEM opcode with target >= NUM_MEM, produces tx 0xEE and a return to IDLE.
- States: IDLE, HDR, MEM_RD_ISSUE, MEM_RD_WAIT, MEM_RD_HOLD, MEM_WR_DATA, VAL_RD_WAIT, VAL_RD_SHIFT, VAL_WR_DATA, VAL_WR_COMMIT, ECHO.
- NOP: stays in IDLE.
- ECHO: the next rx byte is transmitted back, then the engine returns to IDLE.
- HDR, MEM ops: ADDR_BYTES address bytes, then 2 count bytes (MSB first).
- HDR, VAL ops: ID_BYTES id bytes.
- Header bytes are shifted in on i_rx_dv only. No tx during HDR.
- MEM_RD:
  - Count 0 returns to IDLE with no access.
  - Otherwise MEM_RD_ISSUE drives o_mem_en[target] = 1 and rw = 1 for exactly one cycle.
  - MEM_RD_WAIT captures the target's slice, pulses o_tx_dv with it, then enters MEM_RD_HOLD.
  - Each subsequent i_rx_dv (dummy byte) increments the address and decrements the count. If count is still > 0, go to MEM_RD_ISSUE; else go to IDLE.
  - Latency: header last byte to first tx_dv = 3 cycles.
- MEM_WR:
  - Count 0 returns to IDLE.
  - Each rx byte in MEM_WR_DATA drives en[target], rw = 0, o_mem_data = byte for one cycle (the cycle after rx_dv), then increments the address and decrements the count. Count 0 after decrement returns to IDLE. No tx.
- Address arithmetic wraps modulo 2^ADDR_W. The count is an unsigned 16-bit value; 0xFFFF gives 65535 transfers.
- VAL_RD:
  - After the id, o_value_en = 1 and rw = 1 for one cycle. Capture i_value_data next cycle into a shift register.
  - Transmit the MSB byte immediately (tx_dv).
  - Each following rx_dv transmits the next byte. After VALUE_BYTES bytes, the next rx_dv returns to IDLE.
  - Upper pad bits, when VALUE_W is not a multiple of 8, read 0.
- VAL_WR: collect VALUE_BYTES bytes, then VAL_WR_COMMIT drives en = 1, rw = 0, data for one cycle and returns to IDLE.
- Enables are only ever single-cycle pulses. Between accesses, o_mem_en = 0 and o_value_en = 0.
- i_sync_clear: next state IDLE. Any in-flight enable is deasserted the following cycle and partial headers are discarded. A write enable that is already asserted completes. No tx. If i_sync_clear and i_rx_dv are asserted together, i_sync_clear wins and the byte is dropped.
- An i_rx_dv arriving in a non-accepting state (ISSUE/WAIT/COMMIT) is dropped. The host spaces bytes by at least 4 clocks, which is guaranteed by the SPI rate.

Optional Feature:
DEBUG_CMD_ENGINE_STATUS_EN:
- Defined: adds output ports o_debug_state (4 bits, state encoding) and o_debug_bytes_remaining (16 bits, current count), plus a sticky o_debug_error that is set on an 0xEE response and cleared by i_sync_clear.
- Undefined: these ports and their registers are absent, and the functional behaviour is identical.

Decomposition:
- Package debug_cmd_pkg: opcode constants, the state enum, the TX_ACK error byte 0xEE, and the count width (16).
- One sub-module, debug_hdr_shifter: a parametrised byte-wise MSB-first shift/collect register with a byte counter and a done flag. It is instantiated for address+count, id, and value write data.

Test Plan:
- Reset/IDLE: assert i_reset mid-idle -> o_mem_rw = 1, o_value_rw = 1, all enables 0, no tx_dv. Then rx 0x10 (ECHO), 0x5A -> tx 0x10 then tx 0x5A.
- MEM_WR then MEM_RD, target 1: rx 0x31, 0x12, 0x34, 0x00, 0x03, 0xAA, 0xBB, 0xCC -> en = 0b10 writes at 0x1234..0x1236. Then 0x21, 0x12, 0x34, 0x00, 0x03 + 3 dummies -> tx 0x21, 0xAA, 0xBB, 0xCC, with first data 3 cycles after the last header byte.
- Wrap: MEM_RD target 0 at 0xFFFF, count 2 -> o_mem_addr sequence 0xFFFF, 0x0000.
- VAL_WR/VAL_RD: rx 0x50, 0x00, 0x07, 0xBE, 0xEF -> one en pulse, id 0x0007, data 0xBEEF. Then 0x40, 0x00, 0x07 + 2 dummies -> tx 0x40, 0xBE, 0xEF.
- Errors: rx 0x22 with NUM_MEM = 2 -> tx 0xEE, IDLE. rx 0x90 -> tx 0xEE. With status macro defined, o_debug_error = 1 until i_sync_clear.
- Abort: MEM_WR header with only 2 of 4 bytes, then i_sync_clear -> IDLE, no enables. A new 0x10 is echoed correctly.
